// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debug_pkg
// Purpose  : Shared constants and types for the debug probe unit: host
//            opcodes, one-byte acknowledge codes and the command FSM states.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package debug_pkg;

  // Command opcodes carried in cmd_data[5:0]
  localparam logic [5:0] OP_STEP     = 6'h38;
  localparam logic [5:0] OP_RUN      = 6'h3F;
  localparam logic [5:0] OP_HALT     = 6'h3E;
  localparam logic [5:0] OP_READ_CNT = 6'h3D;

  // Single-byte responses
  localparam logic [7:0] ACK_STEP = 8'h55;
  localparam logic [7:0] ACK_RUN  = 8'hFF;
  localparam logic [7:0] ACK_HALT = 8'h00;
  localparam logic [7:0] NAK      = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SEND = 2'd2
  } state_t;

endpackage : debug_pkg
`default_nettype wire

// File: rtl/debug_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : debug_tx_shifter
// Purpose  : 32-bit load/shift register with a 2-bit remaining-byte counter
//            driving a valid/ready byte channel, MSB first.
// Ports    : clk, reset        - clock, async active-high reset
//            load              - capture load_data / load_nb_m1 this cycle
//            load_data[31:0]   - right-aligned response field
//            load_nb_m1[1:0]   - number of bytes to send minus one
//            tx_valid/tx_data  - response byte channel (out)
//            tx_ready          - consumer accepts byte (in)
//            done              - last byte handshake happening this cycle
// Revision : 1.0  initial release
// ============================================================================
module debug_tx_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [1:0]  load_nb_m1,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic        pend_q,  pend_d;
  logic        valid_q, valid_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    done    = valid_q & tx_ready & (cnt_q == 2'd0);
    if (load) begin
      // Align byte index load_nb_m1 to the top so MSB-first shifting works
      shreg_d = load_data << {2'd3 - load_nb_m1, 3'b000};
      cnt_d   = load_nb_m1;
      pend_d  = 1'b1;
    end else if (pend_q) begin
      // One-cycle gap between load and first valid sets the response latency
      pend_d  = 1'b0;
      valid_d = 1'b1;
    end else if (valid_q && tx_ready) begin
      shreg_d = {shreg_q[23:0], 8'h00};
      cnt_d   = cnt_q - 2'd1;
      if (cnt_q == 2'd0) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = shreg_q[31:24];

endmodule : debug_tx_shifter
`default_nettype wire

// File: rtl/debug_probe_unit.sv
`default_nettype none
// ============================================================================
// Module   : debug_probe_unit
// Purpose  : Host command decoder for pipeline debug: single-step, run, halt,
//            step-count readback and 1-4 byte probe snapshots.
// Ports    : clk, reset              - clock, async active-high reset
//            cmd_valid/cmd_data/cmd_ready - host command byte channel
//            probe_bus               - N_PROBES flattened DATA_W probes
//            tx_valid/tx_data/tx_ready - response byte channel
//            cpu_step_en             - pipeline clock enable
//            running                 - continuous-run mode active
//            step_count              - enabled cycles since reset (wraps)
// Revision : 1.0  initial release
// ============================================================================
module debug_probe_unit
  import debug_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int N_PROBES = 32,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  input  logic [7:0]                 cmd_data,
  output logic                       cmd_ready,
  input  logic [N_PROBES*DATA_W-1:0] probe_bus,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       cpu_step_en,
  output logic                       running,
  output logic [CNT_W-1:0]           step_count
);

  localparam logic [6:0] NPROBE_LIM   = 7'(N_PROBES);
  localparam logic [1:0] PROBE_NB_MAX = 2'(DATA_W/8 - 1);

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             running_q, running_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;

  logic              step_pulse;
  logic              sh_load;
  logic [31:0]       sh_data;
  logic [1:0]        sh_nb_m1;
  logic              sh_done;
  logic [DATA_W-1:0] probe_val;
  logic [5:0]        op;
  logic [1:0]        size;

  assign op   = cmd_q[5:0];
  assign size = cmd_q[7:6];

  // Probe select; out-of-range codes never reach the READ_PROBE path
  always_comb begin
    probe_val = '0;
    for (int k = 0; k < N_PROBES; k++) begin
      if (op == 6'(k)) begin
        probe_val = probe_bus[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    running_d  = running_q;
    step_pulse = 1'b0;
    sh_load    = 1'b0;
    sh_data    = '0;
    sh_nb_m1   = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d   = cmd_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        sh_load = 1'b1;
        state_d = ST_SEND;
        case (op)
          OP_STEP: begin
            if (!running_q) begin
              step_pulse   = 1'b1;
              sh_data[7:0] = ACK_STEP;
            end else begin
              sh_data[7:0] = NAK;
            end
          end
          OP_RUN: begin
            running_d    = 1'b1;
            sh_data[7:0] = ACK_RUN;
          end
          OP_HALT: begin
            running_d    = 1'b0;
            sh_data[7:0] = ACK_HALT;
          end
          OP_READ_CNT: begin
            sh_data[CNT_W-1:0] = step_count_q;
            sh_nb_m1           = size;
          end
          default: begin
            if ({1'b0, op} < NPROBE_LIM) begin
              sh_data[DATA_W-1:0] = probe_val;
              sh_nb_m1 = (size > PROBE_NB_MAX) ? PROBE_NB_MAX : size;
            end else begin
              sh_data[7:0] = NAK;
            end
          end
        endcase
      end
      ST_SEND: begin
        if (sh_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered so that cmd_ready stays low while reset is asserted
    cmd_ready_d  = (state_d == ST_IDLE);
    step_count_d = step_count_q + {{(CNT_W-1){1'b0}}, cpu_step_en};
  end

  assign cpu_step_en = running_q | step_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      running_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      running_q    <= running_d;
      cmd_ready_q  <= cmd_ready_d;
      step_count_q <= step_count_d;
    end
  end

  debug_tx_shifter u_tx (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load),
    .load_data  (sh_data),
    .load_nb_m1 (sh_nb_m1),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .done       (sh_done)
  );

  assign cmd_ready  = cmd_ready_q;
  assign running    = running_q;
  assign step_count = step_count_q;

endmodule : debug_probe_unit
`default_nettype wire

// File: tb/tb_debug_probe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_probe_unit
// Purpose  : Self-checking bench for debug_probe_unit with a byte scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_debug_probe_unit;

  localparam int DATA_W   = 32;
  localparam int N_PROBES = 32;
  localparam int CNT_W    = 16;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       cmd_valid;
  logic [7:0]                 cmd_data;
  logic                       cmd_ready;
  logic [N_PROBES*DATA_W-1:0] probe_bus;
  logic                       tx_valid;
  logic [7:0]                 tx_data;
  logic                       tx_ready;
  logic                       cpu_step_en;
  logic                       running;
  logic [CNT_W-1:0]           step_count;

  int checks = 0;
  int errors = 0;
  int en_cycles = 0;
  logic [7:0] sb[$];

  debug_probe_unit #(.DATA_W(DATA_W), .N_PROBES(N_PROBES), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .probe_bus   (probe_bus),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .cpu_step_en (cpu_step_en),
    .running     (running),
    .step_count  (step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference count of enabled cycles
  always @(negedge clk) begin
    if (reset) en_cycles = 0;
    else if (cpu_step_en) en_cycles = en_cycles + 1;
  end

  // Monitor: every accepted response byte is compared against the scoreboard
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_tx_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 300) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [7:0] b);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_data  = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !cmd_ready) && n < 300) begin
      tick();
      n++;
    end
    if (sb.size() != 0 || !cmd_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_bytes(input logic [31:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) sb.push_back(v[i*8 +: 8]);
  endtask

  initial begin
    logic [15:0] cnt_exp;
    int          n;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
    cnt_exp = '0;
    n = 0;
  end

  initial begin
    logic [15:0] cnt_exp;
    int          n;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    tx_ready  = 1'b1;
    probe_bus = '0;
    for (int k = 0; k < N_PROBES; k++) probe_bus[k*DATA_W +: DATA_W] = 32'h1000_0000 + k;
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_step_en", {31'd0, cpu_step_en}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_step_count", {16'd0, step_count}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single step: pulse in EXEC only, tx two cycles after accept, period 4
    sb.push_back(8'h55);
    issue(8'h38);
    chk("step_pulse_exec", {31'd0, cpu_step_en}, 32'd1);
    chk("step_tx_lat0", {31'd0, tx_valid}, 32'd0);
    tick();
    chk("step_pulse_end", {31'd0, cpu_step_en}, 32'd0);
    chk("step_tx_lat1", {31'd0, tx_valid}, 32'd0);
    chk("step_busy", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("step_tx_lat2", {31'd0, tx_valid}, 32'd1);
    tick();
    chk("step_ready_back", {31'd0, cmd_ready}, 32'd1);
    wait_idle();
    chk("step_count_1", {16'd0, step_count}, 32'd1);
    chk("step_en_cycles", en_cycles, 32'd1);

    // Probe reads: 4 bytes MSB first, then single byte
    probe_bus[5*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    push_bytes(32'hDEAD_BEEF, 4);
    issue(8'hC5);
    wait_idle();
    sb.push_back(8'hEF);
    issue(8'h05);
    wait_idle();
    push_bytes(32'h1000_001F, 2);
    issue(8'h5F);
    wait_idle();

    // Run, step-while-running, unknown opcode, halt, read counter
    sb.push_back(8'hFF);
    issue(8'h3F);
    wait_idle();
    chk("run_running", {31'd0, running}, 32'd1);
    chk("run_step_en", {31'd0, cpu_step_en}, 32'd1);
    repeat (100) tick();
    sb.push_back(8'hEE);
    issue(8'h38);
    wait_idle();
    chk("step_while_run", {31'd0, running}, 32'd1);
    sb.push_back(8'hEE);
    issue(8'h30);
    wait_idle();
    sb.push_back(8'h00);
    issue(8'h3E);
    wait_idle();
    chk("halt_running", {31'd0, running}, 32'd0);
    chk("halt_step_en", {31'd0, cpu_step_en}, 32'd0);
    cnt_exp = en_cycles[15:0];
    chk("count_ge_100", {31'd0, (en_cycles >= 101)}, 32'd1);
    chk("count_model", {16'd0, step_count}, {16'd0, cnt_exp});
    push_bytes({16'd0, cnt_exp}, 2);
    issue(8'h7D);
    wait_idle();

    // Back-pressure stall with probe change during the stall
    tx_ready = 1'b0;
    probe_bus[5*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    push_bytes(32'hDEAD_BEEF, 4);
    issue(8'hC5);
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    chk("stall_tx_valid", {31'd0, tx_valid}, 32'd1);
    probe_bus[5*DATA_W +: DATA_W] = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_tx_data", {24'd0, tx_data}, 32'h0000_00DE);
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    tx_ready = 1'b1;
    wait_idle();

    // Reset during the second byte of a 4-byte send while running
    sb.push_back(8'hFF);
    issue(8'h3F);
    wait_idle();
    probe_bus[5*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    sb.push_back(8'hDE);
    issue(8'hC5);
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("pre_reset_byte2", {24'd0, tx_data}, 32'h0000_00AD);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_running", {31'd0, running}, 32'd0);
    chk("mid_rst_step_en", {31'd0, cpu_step_en}, 32'd0);
    chk("mid_rst_step_count", {16'd0, step_count}, 32'd0);
    chk("mid_rst_sb_empty", sb.size(), 32'd0);
    sb.delete();
    tick(); tick();
    reset = 1'b0;
    tick();
    sb.push_back(8'hEF);
    issue(8'h05);
    wait_idle();
    push_bytes(32'd0, 4);
    issue(8'hFD);
    wait_idle();
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_debug_probe_unit
`default_nettype wire
